mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sharing one 16-bit memory bus between the instruction fetch path and the load/store path. Sits between the fetch unit, whose memory-ready input is driven by `fe_rdy`, and the external memory. Load/store has priority, with a starvation guard for fetch. Completed transactions are returned as one-cycle ready pulses with registered data.

## Interface
- `STARVE_LIMIT`, default 4: consecutive load/store grants, with fetch pending, after which fetch wins the next arbitration.
- `TIMEOUT_CYCLES`, default 255: busy cycles without `mem_ack` before abort. Used only with the timeout macro.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fe_req` in 1: fetch request; held, with `fe_addr`, until `fe_rdy`.
- `fe_addr` in 16: fetch address.
- `fe_rdy` out 1: one-cycle pulse; `fe_data` is valid this cycle.
- `fe_data` out 16: fetched word.
- `ls_req` in 1: load/store request; held, with the other `ls_*` inputs, until `ls_rdy`.
- `ls_we` in 1: 1 = write, 0 = read.
- `ls_addr` in 16: data address.
- `ls_wdata` in 16: write data.
- `ls_rdy` out 1: one-cycle completion pulse.
- `ls_rdata` out 16: read data.
- `mem_en` out 1: transaction active.
- `mem_we` out 1: write strobe, valid while `mem_en`.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data, sampled on `mem_ack`.
- `mem_ack` in 1: memory done; ignored unless busy.
- `o_err` out 1: one-cycle pulse on timeout abort.

## Operation
- **States:** IDLE, FE_BUSY, LS_BUSY. Reset state is IDLE.
- **IDLE arbitration:**
  - Only `ls_req`: go to LS_BUSY.
  - Only `fe_req`: go to FE_BUSY.
  - Both requests: LS_BUSY, unless `streak == STARVE_LIMIT`, in which case FE_BUSY.
  - Neither: stay in IDLE.
- **Starvation counter `streak`:** width `$clog2(STARVE_LIMIT+1)`.
  - Increments on an LS grant while `fe_req` is high; saturates at `STARVE_LIMIT`.
  - Clears on any FE grant.
- **Busy outputs:** `mem_en=1`; `mem_addr`, `mem_we` and `mem_wdata` are driven from the granted requester's live inputs. In FE_BUSY, `mem_we=0` and `mem_wdata=0`.
- **Completion:** on a clock edge in BUSY with `mem_ack=1`:
  - The granted `*_rdy` is set for the following cycle.
  - Returns to IDLE.
  - `fe_data` is loaded from `mem_rdata` for a fetch; `ls_rdata` is loaded for an LS read only. An LS write leaves `ls_rdata` unchanged.
- **New requests:** if `*_req` is still high in the cycle its `*_rdy` pulses, that is a new request and is arbitrated in that same IDLE cycle.
- **Request dropped while busy:** the transaction still completes and `*_rdy` still pulses.
- **Idle outputs:** `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are all 0.

## Timing
- Request high in the IDLE cycle at edge N → BUSY with `mem_en=1` from N+1.
- Minimum latency: zero-wait memory (`mem_ack` high in the first busy cycle) gives `*_rdy` at N+2.
- Throughput: at most one transaction per 2 cycles, because IDLE is always visited between transactions.
- `fe_rdy` and `ls_rdy` are never high in the same cycle.
- **Reset values:** all outputs 0; `fe_data` and `ls_rdata` are 0; `streak` is 0; state is IDLE.
- **Reset mid-transaction:** the edge with `rst=1` aborts with no `*_rdy`; `mem_en` is 0 from the next cycle.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:**
  - A busy-cycle counter clears on entry to BUSY.
  - When it reaches `TIMEOUT_CYCLES` without `mem_ack`, the transaction ends as a completion with data `16'h0000`; `o_err` pulses with the `*_rdy`.
  - The data load follows the completion rules (`fe_data`, LS reads only).
  - `mem_ack` in the expiry cycle wins; there is no error.
- **Undefined:** BUSY waits indefinitely for `mem_ack`; `o_err` is tied to 0.

## Structure
- Shared package `qisp_mem_pkg` holds the state encoding localparams (IDLE=2'b00, FE_BUSY=2'b01, LS_BUSY=2'b10) and the 16-bit address/data width constants.
- One sub-module, `mem_arb_watchdog`: the timeout counter, instantiated only under `MEM_ARB_TIMEOUT_EN`. Arbitration and datapath stay in `mem_arbiter`.

## Test plan
- **Fetch, zero-wait:** `fe_req=1`, `fe_addr=16'h0010`, `mem_ack` tied to 1, `mem_rdata=16'h1234` → `mem_en` at N+1, `fe_rdy=1` with `fe_data=16'h1234` at N+2.
- **Simultaneous requests:** `fe_req` and `ls_req` rise together (`ls_we=0`) → LS granted first. With `fe_req` held and `ls_req` re-asserted after each `ls_rdy`, fetch is granted after exactly 4 LS grants (`STARVE_LIMIT=4`).
- **Write with wait states:** `ls_we=1`, `ls_addr=16'h8000`, `ls_wdata=16'hBEEF`, `mem_ack` delayed 3 cycles → `mem_we=1` and `mem_wdata=16'hBEEF` for 3 cycles, `ls_rdy` one cycle later, `ls_rdata` unchanged.
- **Reset mid-transaction:** `rst` pulsed in cycle 2 of FE_BUSY → no `fe_rdy`; IDLE and all outputs 0 next cycle.
- **Timeout (macro defined, `TIMEOUT_CYCLES=8`):** `mem_ack` never asserts → `fe_rdy` and `o_err` pulse together, `fe_data=16'h0000`.
- **Dropped request:** `fe_req` drops while busy → `fe_rdy` still pulses on `mem_ack`; the next cycle is IDLE.

Source files
------------

// File: rtl/qisp_mem_pkg.sv
// qisp_mem_pkg: state encoding and bus widths shared by the memory arbiter slice
package qisp_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_FE_BUSY = 2'b01;
    localparam logic [1:0] ST_LS_BUSY = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        FE_BUSY = ST_FE_BUSY,
        LS_BUSY = ST_LS_BUSY
    } arb_state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals of the arbiter
//   fe_*  : fetch requester (req/addr in, rdy/data out)
//   ls_*  : load/store requester (req/we/addr/wdata in, rdy/rdata out)
//   mem_* : external single-port memory (en/we/addr/wdata out, rdata/ack in)
//   o_err : timeout abort pulse
//   slave modport is the arbiter's view, master is the requesters'/memory's view
interface mem_arbiter_if;
    import qisp_mem_pkg::*;

    logic  fe_req;
    addr_t fe_addr;
    logic  fe_rdy;
    data_t fe_data;

    logic  ls_req;
    logic  ls_we;
    addr_t ls_addr;
    data_t ls_wdata;
    logic  ls_rdy;
    data_t ls_rdata;

    logic  mem_en;
    logic  mem_we;
    addr_t mem_addr;
    data_t mem_wdata;
    data_t mem_rdata;
    logic  mem_ack;

    logic  o_err;

    modport slave (
        input  fe_req, fe_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
        output fe_rdy, fe_data, ls_rdy, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata, o_err
    );

    modport master (
        output fe_req, fe_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
        input  fe_rdy, fe_data, ls_rdy, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata, o_err
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: busy-cycle counter that flags a memory transaction timeout
//   clk, rst : clock, synchronous active-high reset
//   busy     : arbiter is in a busy state
//   expired  : high in the TIMEOUT_CYCLES-th consecutive busy cycle
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // IDLE is visited between every pair of transactions, so holding the
    // count at zero while idle clears it on each entry to BUSY.
    always_ff @(posedge clk) begin
        cnt_q <= (rst || !busy) ? '0 : cnt_q + 1'b1;
    end

    assign expired = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit memory bus between fetch and load/store
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave carrying fe_*, ls_*, mem_* and o_err
// Load/store wins arbitration unless fetch has been passed over STARVE_LIMIT
// times in a row. Completions are one-cycle *_rdy pulses with registered data.
// Define MEM_ARB_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES busy
// cycles without mem_ack (o_err pulses); otherwise BUSY waits indefinitely.
module mem_arbiter
    import qisp_mem_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          fe_rdy_q, ls_rdy_q;
    data_t         fe_data_q, ls_rdata_q;
    logic          busy, expired, done, starved, grant_ls, grant_fe;
    data_t         rdata;

    assign busy    = state_q != IDLE;
    assign done    = busy && (bus.mem_ack || expired);
    assign starved = streak_q == SW'(STARVE_LIMIT);
    // An ack in the expiry cycle wins; a pure timeout returns zero data.
    assign rdata   = bus.mem_ack ? bus.mem_rdata : '0;

    always_comb begin
        grant_ls = 1'b0;
        grant_fe = 1'b0;
        state_d  = state_q;
        if (state_q == IDLE) begin
            grant_ls = bus.ls_req && !(bus.fe_req && starved);
            grant_fe = bus.fe_req && !grant_ls;
            state_d  = grant_ls ? LS_BUSY : grant_fe ? FE_BUSY : IDLE;
        end else if (done) begin
            state_d = IDLE;
        end
        streak_d = grant_fe                               ? '0 :
                   (grant_ls && bus.fe_req && !starved)   ? streak_q + 1'b1 :
                                                            streak_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fe_rdy_q   <= 1'b0;
            ls_rdy_q   <= 1'b0;
            fe_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            fe_rdy_q <= done && state_q == FE_BUSY;
            ls_rdy_q <= done && state_q == LS_BUSY;
            if (done && state_q == FE_BUSY)
                fe_data_q <= rdata;
            if (done && state_q == LS_BUSY && !bus.ls_we)
                ls_rdata_q <= rdata;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .busy   (busy),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        err_q <= !rst && done && !bus.mem_ack;
    end

    assign bus.o_err = err_q;
`else
    logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] unused_timeout_w;

    assign unused_timeout_w = '0;
    assign expired          = 1'b0;
    assign bus.o_err        = 1'b0;
`endif

    assign bus.fe_rdy    = fe_rdy_q;
    assign bus.fe_data   = fe_data_q;
    assign bus.ls_rdy    = ls_rdy_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_en    = busy;
    assign bus.mem_we    = state_q == LS_BUSY && bus.ls_we;
    assign bus.mem_addr  = state_q == LS_BUSY ? bus.ls_addr :
                           state_q == FE_BUSY ? bus.fe_addr : '0;
    assign bus.mem_wdata = state_q == LS_BUSY ? bus.ls_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    import qisp_mem_pkg::*;

    localparam data_t K = 16'h1224;

    typedef struct packed {
        logic  fe;
        logic  err;
        data_t data;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  sb[$];
    data_t exp_ls;

    mem_arbiter_if bus();

    always #5 clk = ~clk;

    // Memory model: read data is a fixed scramble of the presented address.
    assign bus.mem_rdata = bus.mem_addr ^ K;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    mem_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic fe, input logic err, input data_t d);
        sb.push_back({fe, err, d});
    endtask

    task automatic check_rdy();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("fe_rdy", bus.fe_rdy, e.fe);
        check("ls_rdy", bus.ls_rdy, !e.fe);
        if (e.fe)
            check("fe_data", bus.fe_data, e.data);
        else
            check("ls_rdata", bus.ls_rdata, e.data);
        check("o_err", bus.o_err, e.err);
    endtask

    task automatic wait_rdy();
        int i = 0;
        do begin
            tick();
            i++;
        end while (!(bus.fe_rdy || bus.ls_rdy) && i < 40);
        check("rdy_seen", bus.fe_rdy || bus.ls_rdy, 1);
        check("rdy_exclusive", bus.fe_rdy && bus.ls_rdy, 0);
        if (bus.fe_rdy || bus.ls_rdy)
            check_rdy();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.fe_req   = 1'b0;
        bus.fe_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
        bus.mem_ack  = 1'b0;
        exp_ls       = '0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_fe_rdy", bus.fe_rdy, 0);
        check("rst_ls_rdy", bus.ls_rdy, 0);
        check("rst_fe_data", bus.fe_data, 0);
        check("rst_ls_rdata", bus.ls_rdata, 0);
        check("rst_o_err", bus.o_err, 0);
        rst = 1'b0;

        // Fetch, zero-wait memory: mem_en at N+1, fe_rdy at N+2.
        bus.fe_req  = 1'b1;
        bus.fe_addr = 16'h0010;
        bus.mem_ack = 1'b1;
        push(1'b1, 1'b0, 16'h1234);
        tick();
        check("fe_mem_en", bus.mem_en, 1);
        check("fe_mem_addr", bus.mem_addr, 16'h0010);
        check("fe_mem_we", bus.mem_we, 0);
        check("fe_mem_wdata", bus.mem_wdata, 0);
        check("fe_rdy_early", bus.fe_rdy, 0);
        tick();
        check_rdy();
        check("fe_rdy_cycle_idle", bus.mem_en, 0);
        bus.fe_req = 1'b0;
        tick();
        check("fe_rdy_one_cycle", bus.fe_rdy, 0);

        // Simultaneous requests: LS first, fetch after four LS grants.
        bus.fe_req  = 1'b1;
        bus.fe_addr = 16'h0100;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 16'h2000;
        tick();
        check("arb_ls_first", bus.mem_addr, 16'h2000);
        check("arb_ls_we", bus.mem_we, 0);
        push(1'b0, 1'b0, 16'h2000 ^ K);
        wait_rdy();
        exp_ls = 16'h2000 ^ K;
        for (int g = 1; g < 4; g++) begin
            bus.ls_addr = 16'h2000 + 16'(g);
            push(1'b0, 1'b0, bus.ls_addr ^ K);
            wait_rdy();
            exp_ls = bus.ls_addr ^ K;
        end
        bus.ls_addr = 16'h2010;
        tick();
        check("starve_fe_granted", bus.mem_addr, 16'h0100);
        check("starve_fe_we", bus.mem_we, 0);
        push(1'b1, 1'b0, 16'h0100 ^ K);
        wait_rdy();
        bus.fe_req = 1'b0;
        tick();
        check("ls_after_fe", bus.mem_addr, 16'h2010);
        push(1'b0, 1'b0, 16'h2010 ^ K);
        wait_rdy();
        exp_ls = 16'h2010 ^ K;
        bus.ls_req = 1'b0;
        tick();

        // LS write with three busy cycles; ls_rdata must be untouched.
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 16'h8000;
        bus.ls_wdata = 16'hBEEF;
        bus.mem_ack  = 1'b0;
        push(1'b0, 1'b0, exp_ls);
        tick();
        for (int k = 0; k < 3; k++) begin
            check("wr_mem_en", bus.mem_en, 1);
            check("wr_mem_we", bus.mem_we, 1);
            check("wr_mem_wdata", bus.mem_wdata, 16'hBEEF);
            check("wr_mem_addr", bus.mem_addr, 16'h8000);
            check("wr_no_rdy", bus.ls_rdy, 0);
            if (k == 2)
                bus.mem_ack = 1'b1;
            tick();
        end
        check_rdy();
        check("wr_done_idle", bus.mem_en, 0);
        bus.ls_req  = 1'b0;
        bus.ls_we   = 1'b0;
        bus.mem_ack = 1'b0;
        tick();

        // Reset in the second FE_BUSY cycle, with an ack on the same edge.
        bus.fe_req  = 1'b1;
        bus.fe_addr = 16'h0300;
        tick();
        check("rst_mid_busy", bus.mem_en, 1);
        tick();
        rst         = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        rst         = 1'b0;
        bus.fe_req  = 1'b0;
        bus.mem_ack = 1'b0;
        check("rst_mid_fe_rdy", bus.fe_rdy, 0);
        check("rst_mid_mem_en", bus.mem_en, 0);
        check("rst_mid_mem_addr", bus.mem_addr, 0);
        check("rst_mid_fe_data", bus.fe_data, 0);
        check("rst_mid_ls_rdata", bus.ls_rdata, 0);
        exp_ls = '0;
        tick();
        check("rst_mid_no_late_rdy", bus.fe_rdy, 0);
        check("rst_mid_idle", bus.mem_en, 0);

        // Fetch request dropped while busy still completes.
        bus.fe_req  = 1'b1;
        bus.fe_addr = 16'h0040;
        push(1'b1, 1'b0, 16'h0040 ^ K);
        tick();
        bus.fe_req = 1'b0;
        tick();
        check("drop_busy", bus.mem_en, 1);
        check("drop_addr", bus.mem_addr, 16'h0040);
        bus.mem_ack = 1'b1;
        wait_rdy();
        check("drop_rdy_idle", bus.mem_en, 0);
        bus.mem_ack = 1'b0;
        tick();
        check("drop_next_idle", bus.mem_en, 0);
        check("drop_rdy_once", bus.fe_rdy, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack ever: abort after eight busy cycles with zero data and o_err.
        bus.fe_req  = 1'b1;
        bus.fe_addr = 16'h0050;
        push(1'b1, 1'b1, 16'h0000);
        wait_rdy();
        bus.fe_req = 1'b0;
        tick();
        check("timeout_err_once", bus.o_err, 0);
        check("timeout_idle", bus.mem_en, 0);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
